// File: rtl/literal_serializer_if.sv
// literal_serializer_if
//   Groups the serializer's upstream capture inputs, downstream serial
//   handshake and status outputs.
//   master : drives load/y1/y2/ready, observes serial output and status
//   slave  : the serializer itself
interface literal_serializer_if;
    logic       load;
    logic [7:0] y1;
    logic [5:0] y2;
    logic       ready;
    logic       sdo;
    logic       svalid;
    logic       busy;
    logic       frame_end;
    logic [7:0] fcnt;

    modport master (
        output load, y1, y2, ready,
        input  sdo, svalid, busy, frame_end, fcnt
    );

    modport slave (
        input  load, y1, y2, ready,
        output sdo, svalid, busy, frame_end, fcnt
    );
endinterface

// File: rtl/literal_serializer.sv
// literal_serializer
//   Captures a 14-bit literal {y1, y2} on load and sends it serially with a
//   ready/valid handshake, followed by one parity bit. Counts completed frames.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : literal_serializer_if.slave (load, y1, y2, ready in;
//           sdo, svalid, busy, frame_end, fcnt out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for load; outputs quiet
//   S_SHIFT | presenting data bits 0..13, advance on ready
//   S_PAR   | presenting parity bit, leave on ready
//   S_DONE  | one-cycle frame_end pulse, frame counter bumps on exit
module literal_serializer #(
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PAR_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    literal_serializer_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_PAR   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [13:0] shreg;
    logic        par_bit;
    logic [3:0]  idx;
    logic [7:0]  fcnt_q;

    logic [13:0] data_in;
    logic [13:0] data_ord;
    logic        par_calc;

    // The shift register always sends from bit 13, so LSB-first order is
    // produced by bit-reversing the word at capture time.
    always_comb begin
        data_in  = {bus.y1, bus.y2};
        data_ord = data_in;
        if (!MSB_FIRST) begin
            for (int i = 0; i < 14; i++) begin
                data_ord[i] = data_in[13-i];
            end
        end
        par_calc = (^data_in) ^ PAR_ODD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            par_bit <= 1'b0;
            idx     <= '0;
            fcnt_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load) begin
                        shreg   <= data_ord;
                        par_bit <= par_calc;
                        idx     <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.ready) begin
                        shreg <= {shreg[12:0], 1'b0};
                        if (idx == 4'd13) begin
                            idx   <= '0;
                            state <= S_PAR;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (bus.ready) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    fcnt_q <= fcnt_q + 8'd1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    always_comb begin
        bus.svalid    = (state == S_SHIFT) || (state == S_PAR);
        bus.busy      = (state != S_IDLE);
        bus.frame_end = (state == S_DONE);
        bus.fcnt      = fcnt_q;
        bus.sdo       = 1'b0;
        if (state == S_SHIFT) begin
            bus.sdo = shreg[13];
        end else if (state == S_PAR) begin
            bus.sdo = par_bit;
        end
    end

endmodule
